// File: rtl/csa_accumulator_pkg.sv
// Shared definitions for the carry-save streaming accumulator.
// Holds the default widths and the FSM state encoding.
package csa_accumulator_pkg;

    localparam int unsigned DEF_W  = 8;
    localparam int unsigned DEF_CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand stream in, resolved result out; both use valid/ready handshakes.
interface csa_accumulator_if
    import csa_accumulator_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_ovf;
    logic [CW-1:0] out_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_cnt
    );

endinterface

// File: rtl/csa_accumulator_carry_save_adder.sv
// One row of full adders: three W-bit operands reduced to sum and carry vectors.
module carry_save_adder #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: beats fold into redundant sum/carry
// registers, and a single resolve cycle produces the binary total.
module csa_accumulator
    import csa_accumulator_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
) (
    input logic               clk,
    input logic               rst_n,
    csa_accumulator_if.slave  bus
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e        state_q, state_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  c_q, c_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_sum_q, out_sum_d;
    logic          out_ovf_q, out_ovf_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    logic          in_ready;
    logic          accept;
    logic [W-1:0]  csa_s;
    logic [W-1:0]  csa_co;
    logic [W:0]    resolve_sum;

    carry_save_adder #(.W(W)) u_csa (
        .a  (s_q),
        .b  (c_q),
        .c  (bus.in_data),
        .s  (csa_s),
        .co (csa_co)
    );

    assign accept      = bus.in_valid && in_ready;
    // The only carry-propagate add; it is only consumed in RESOLVE.
    assign resolve_sum = {1'b0, s_q} + {1'b0, c_q};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_d = bus.in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_RESOLVE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_d       = s_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        out_cnt_d = out_cnt_q;

        if (accept) begin
            s_d   = csa_s;
            // Carry weight is one bit up; the top carry has weight 2^W and only
            // contributes to overflow.
            c_d   = {csa_co[W-2:0], 1'b0};
            ovf_d = ovf_q | csa_co[W-1];
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end

        if (state_q == ST_RESOLVE) begin
            out_sum_d = resolve_sum[W-1:0];
            out_ovf_d = ovf_q | resolve_sum[W];
            out_cnt_d = cnt_q;
        end

        if (state_q == ST_HOLD && bus.out_ready) begin
            s_d   = '0;
            c_d   = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_comb begin
        in_ready      = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
        bus.in_ready  = in_ready;
        bus.out_valid = (state_q == ST_HOLD);
        bus.out_sum   = out_sum_q;
        bus.out_ovf   = out_ovf_q;
        bus.out_cnt   = out_cnt_q;
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomised scoreboard bench for csa_accumulator: groups are summed with plain
// integer arithmetic and compared by a monitor on each output handshake.
module tb_csa_accumulator;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [W-1:0]  sum;
        logic          ovf;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t         exp_q[$];
    logic [W-1:0] beats[$];

    csa_accumulator_if #(.W(W), .CW(CW)) bus ();

    csa_accumulator #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_sum", 32'(bus.out_sum), 32'(e.sum));
                    check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                    check("out_cnt", 32'(bus.out_cnt), 32'(e.cnt));
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int guard;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check("beat_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_group(input bit bubble, input int hold);
        int total;
        int n;
        int guard;
        total         = 0;
        n             = beats.size();
        bus.out_ready = (hold == 0);
        for (int i = 0; i < n; i++) begin
            send_beat(beats[i], i == n - 1);
            total += int'(beats[i]);
            if (bubble && i != n - 1) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        exp_q.push_back('{sum: total[W-1:0], ovf: (total >= (1 << W)),
                          cnt: (n > 15) ? CW'(15) : CW'(n)});

        // In RESOLVE: nothing visible yet, input stalled.
        check("resolve_ready", 32'(bus.in_ready), 32'd0);
        check("resolve_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_ready", 32'(bus.in_ready), 32'd0);

        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hFF;
            bus.in_last  = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                check("bp_valid", 32'(bus.out_valid), 32'd1);
                check("bp_sum", 32'(bus.out_sum), 32'(total[W-1:0]));
                check("bp_ready", 32'(bus.in_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end

        guard = 0;
        while (bus.out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("handshake_done", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #12;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.out_sum), 32'd0);
        check("rst_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_cnt", 32'(bus.out_cnt), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Eight neighbour bits.
        beats = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        run_group(1'b0, 0);

        // Overflow cases.
        beats = {8'd200, 8'd100};
        run_group(1'b0, 0);
        beats = {8'd128, 8'd127, 8'd1};
        run_group(1'b0, 0);

        // Single beat straight from IDLE.
        beats = {8'hA5};
        run_group(1'b0, 0);

        // Backpressure for five cycles, then a fresh group.
        beats = {8'd10, 8'd20};
        run_group(1'b0, 5);
        beats = {8'd7, 8'd9};
        run_group(1'b0, 0);

        // Bubbles and counter saturation.
        beats.delete();
        for (int i = 0; i < 20; i++) beats.push_back(8'd3);
        run_group(1'b1, 0);

        // Asynchronous reset mid-group discards the partial sum.
        for (int i = 0; i < 3; i++) send_beat(8'(40 + i), 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.out_sum), 32'd0);
        check("mid_rst_ovf", 32'(bus.out_ovf), 32'd0);
        check("mid_rst_cnt", 32'(bus.out_cnt), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beats = {8'd5, 8'd6};
        run_group(1'b0, 0);

        // Random groups with random bubbles and output stalls.
        for (int g = 0; g < 25; g++) begin
            int len;
            len = int'($urandom_range(1, 20));
            beats.delete();
            for (int i = 0; i < len; i++) beats.push_back(8'($urandom_range(0, 255)));
            run_group(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
